// File: rtl/dm_access_arbiter_if.sv
// Bus bundle between the two requesters (C = CPU MEM stage, X = bridge),
// the data-memory arbiter and the single-port DM array.
//
// Handshake: a requester raises *_req with we/addr/size/wdata stable and
// holds them until the one-cycle *_ack pulse. *_err and *_rdata are valid
// only while *_ack is high and read as 0 otherwise. After the ack cycle the
// requester may drop *_req or present a new request. The memory side samples
// mem_en/mem_we/mem_addr/mem_be/mem_wdata on the rising edge; mem_rdata is
// valid MEM_LAT cycles later.
interface dm_access_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [1:0]        c_size;
  logic [31:0]       c_wdata;
  logic              c_ack;
  logic              c_err;
  logic [31:0]       c_rdata;
  logic              c_stall;

  logic              x_req;
  logic              x_we;
  logic [ADDR_W-1:0] x_addr;
  logic [1:0]        x_size;
  logic [31:0]       x_wdata;
  logic              x_ack;
  logic              x_err;
  logic [31:0]       x_rdata;
  logic              x_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Arbiter view.
  modport slave (
    input  c_req, c_we, c_addr, c_size, c_wdata,
    input  x_req, x_we, x_addr, x_size, x_wdata,
    input  mem_rdata,
    output c_ack, c_err, c_rdata, c_stall,
    output x_ack, x_err, x_rdata, x_stall,
    output mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );

  // Requester / memory-model view.
  modport master (
    output c_req, c_we, c_addr, c_size, c_wdata,
    output x_req, x_we, x_addr, x_size, x_wdata,
    output mem_rdata,
    input  c_ack, c_err, c_rdata, c_stall,
    input  x_ack, x_err, x_rdata, x_stall,
    input  mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/dm_access_arbiter.sv
// Data-memory access arbiter: shares one single-port DM between port C
// and port X. Latches one request, checks alignment, builds byte enables
// and lane-replicated write data, waits MEM_LAT cycles and returns a
// one-cycle ack with right-aligned zero-extended read data.
// Optional macro DM_ARB_RR_EN: round-robin tie-break instead of fixed
// C-first priority.
module dm_access_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  dm_access_arbiter_if.slave  bus,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic              owner_q;    // 0 = port C, 1 = port X
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [3:0]        cnt_q;

  logic              any_req;
  logic              sel_x;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [31:0]       r_wdata;
  logic              illegal;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic [31:0]       rd_ext;

  assign any_req = bus.c_req | bus.x_req;

`ifdef DM_ARB_RR_EN
  logic rr_q;  // last granted port; starts at X so C wins the first tie

  // Tie goes to the port that was not granted last; a lone requester always wins.
  always_comb begin
    if (bus.c_req && bus.x_req) sel_x = ~rr_q;
    else                        sel_x = ~bus.c_req;
  end

  // Pointer follows every accept, including accepts that end in an error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         rr_q <= 1'b1;
    else if (state == S_IDLE && any_req)  rr_q <= sel_x;
  end
`else
  // Fixed priority: X is served only while C is not requesting.
  always_comb sel_x = ~bus.c_req;
`endif

  // Select the granted port's request and classify its alignment.
  always_comb begin
    r_we    = sel_x ? bus.x_we    : bus.c_we;
    r_addr  = sel_x ? bus.x_addr  : bus.c_addr;
    r_size  = sel_x ? bus.x_size  : bus.c_size;
    r_wdata = sel_x ? bus.x_wdata : bus.c_wdata;
    illegal = (r_size == 2'd0) ||
              (r_size == 2'd2 && r_addr[0]) ||
              (r_size == 2'd3 && r_addr[1:0] != 2'b00);
  end

  // Byte enables and lane-replicated store data from the latched request.
  always_comb begin
    be = 4'b1111;
    wd = wdata_q;
    case (size_q)
      2'd1: begin
        be = 4'b0001 << addr_q[1:0];
        wd = {4{wdata_q[7:0]}};
      end
      2'd2: begin
        be = addr_q[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Right-align and zero-extend the addressed lane(s) of the memory word.
  always_comb begin
    rd_ext = bus.mem_rdata;
    case (size_q)
      2'd1: begin
        case (addr_q[1:0])
          2'd0:    rd_ext = {24'd0, bus.mem_rdata[7:0]};
          2'd1:    rd_ext = {24'd0, bus.mem_rdata[15:8]};
          2'd2:    rd_ext = {24'd0, bus.mem_rdata[23:16]};
          default: rd_ext = {24'd0, bus.mem_rdata[31:24]};
        endcase
      end
      2'd2:    rd_ext = addr_q[1] ? {16'd0, bus.mem_rdata[31:16]}
                                  : {16'd0, bus.mem_rdata[15:0]};
      default: ;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state: misaligned requests skip the memory and answer next cycle.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (any_req) state_nx = illegal ? S_RESP : S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (cnt_q == 4'd1) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Request latch, latency counter and response capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      cnt_q   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner_q <= sel_x;
            we_q    <= r_we;
            addr_q  <= r_addr;
            size_q  <= r_size;
            wdata_q <= r_wdata;
            err_q   <= illegal;
            rdata_q <= 32'd0;
          end
        end
        S_ISSUE: cnt_q <= 4'(MEM_LAT);
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) rdata_q <= we_q ? 32'd0 : rd_ext;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; everything idles at 0.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = 4'b0000;
    bus.mem_wdata = 32'd0;
    bus.c_ack     = 1'b0;
    bus.c_err     = 1'b0;
    bus.c_rdata   = 32'd0;
    bus.x_ack     = 1'b0;
    bus.x_err     = 1'b0;
    bus.x_rdata   = 32'd0;
    if (state == S_ISSUE) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = we_q;
      bus.mem_addr  = addr_q[ADDR_W-1:2];
      bus.mem_be    = be;
      bus.mem_wdata = wd;
    end
    if (state == S_RESP) begin
      if (owner_q) begin
        bus.x_ack   = 1'b1;
        bus.x_err   = err_q;
        bus.x_rdata = rdata_q;
      end else begin
        bus.c_ack   = 1'b1;
        bus.c_err   = err_q;
        bus.c_rdata = rdata_q;
      end
    end
    bus.c_stall = bus.c_req & ~(state == S_RESP && !owner_q);
    bus.x_stall = bus.x_req & ~(state == S_RESP &&  owner_q);
    busy        = (state != S_IDLE);
    dbg_state   = state;
  end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Bench for dm_access_arbiter: dut1 runs MEM_LAT=1, dut3 runs MEM_LAT=3,
// each against a small byte-enabled memory model.
module tb_dm_access_arbiter;
  localparam int AW = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dm_access_arbiter_if #(.ADDR_W(AW)) bus1 ();
  dm_access_arbiter_if #(.ADDR_W(AW)) bus3 ();
  logic       busy1, busy3;
  logic [1:0] st1, st3;

  dm_access_arbiter #(.ADDR_W(AW), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .busy(busy1), .dbg_state(st1));
  dm_access_arbiter #(.ADDR_W(AW), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3), .busy(busy3), .dbg_state(st3));

  // ---------------- memory models ----------------
  logic [31:0] mem1 [0:1023];
  logic [31:0] mem3 [0:1023];
  logic [31:0] rd1 = 32'd0;
  logic [31:0] p3_0 = 32'd0, p3_1 = 32'd0, p3_2 = 32'd0;

  always @(posedge clk) begin
    if (bus1.mem_en) begin
      rd1 <= mem1[bus1.mem_addr];
      if (bus1.mem_we)
        for (int b = 0; b < 4; b++)
          if (bus1.mem_be[b]) mem1[bus1.mem_addr][8*b +: 8] <= bus1.mem_wdata[8*b +: 8];
    end
  end
  assign bus1.mem_rdata = rd1;

  always @(posedge clk) begin
    p3_0 <= bus3.mem_en ? mem3[bus3.mem_addr] : 32'd0;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
    if (bus3.mem_en && bus3.mem_we)
      for (int b = 0; b < 4; b++)
        if (bus3.mem_be[b]) mem3[bus3.mem_addr][8*b +: 8] <= bus3.mem_wdata[8*b +: 8];
  end
  assign bus3.mem_rdata = p3_2;

  // ---------------- memory-side / ack monitors ----------------
  int          men1 = 0, men3 = 0, c_acks1 = 0;
  logic [3:0]  be1 = 4'd0, be3 = 4'd0;
  logic [9:0]  ma1 = 10'd0, ma3 = 10'd0;
  logic [31:0] wd1 = 32'd0, wd3 = 32'd0;

  always @(negedge clk) begin
    if (bus1.mem_en) begin
      men1 <= men1 + 1; be1 <= bus1.mem_be; ma1 <= bus1.mem_addr; wd1 <= bus1.mem_wdata;
    end
    if (bus3.mem_en) begin
      men3 <= men3 + 1; be3 <= bus3.mem_be; ma3 <= bus3.mem_addr; wd3 <= bus3.mem_wdata;
    end
    if (bus1.c_ack) c_acks1 <= c_acks1 + 1;
  end

  // ---------------- scoreboard ----------------
  // entry = {ack came from X, err, rdata}
  logic [33:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  function automatic logic [119:0] outs1();
    return {st1, busy1, bus1.c_ack, bus1.c_err, bus1.c_rdata, bus1.x_ack, bus1.x_err,
            bus1.x_rdata, bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_be, bus1.mem_wdata};
  endfunction

  // ---------------- driver tasks ----------------
  // One access on dut1: drive, push expectation, wait for ack, pop and compare.
  task automatic access1(input bit px, input bit we, input logic [AW-1:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata,
                         input bit exp_err, input logic [31:0] exp_rd, input int exp_lat);
    int t0, waited;
    bit seen, stall_bad;
    logic [33:0] e, g;
    @(posedge clk); #1;
    if (px) begin
      bus1.x_req = 1; bus1.x_we = we; bus1.x_addr = addr; bus1.x_size = size; bus1.x_wdata = wdata;
    end else begin
      bus1.c_req = 1; bus1.c_we = we; bus1.c_addr = addr; bus1.c_size = size; bus1.c_wdata = wdata;
    end
    exp_q.push_back({px, exp_err, exp_rd});
    t0 = cyc; seen = 0; stall_bad = 0; waited = 0;
    while (!seen && waited < 40) begin
      @(negedge clk);
      if (px ? bus1.x_ack : bus1.c_ack) begin
        seen = 1;
        if ((px ? bus1.x_stall : bus1.c_stall) !== 1'b0) stall_bad = 1;
      end else begin
        waited++;
        if ((px ? bus1.x_stall : bus1.c_stall) !== 1'b1) stall_bad = 1;
      end
    end
    e = exp_q.pop_front();
    g = {bus1.x_ack & ~bus1.c_ack, px ? bus1.x_err : bus1.c_err, px ? bus1.x_rdata : bus1.c_rdata};
    n_checks++;
    if (!seen) $display("FAIL ack_timeout port=%0d addr=%h: no ack, required one", px, addr);
    else if (g !== e) $display("FAIL resp port=%0d addr=%h: got %h required %h", px, addr, g, e);
    else n_pass++;
    n_checks++;
    if (seen && (cyc - t0) == exp_lat) n_pass++;
    else $display("FAIL latency addr=%h: got %0d required %0d", addr, cyc - t0, exp_lat);
    n_checks++;
    if (!stall_bad) n_pass++;
    else $display("FAIL stall addr=%h: got mismatching stall, required req&~ack", addr);
    @(posedge clk); #1;
    if (px) bus1.x_req = 0; else bus1.c_req = 0;
  endtask

  // One access on dut3 (port C only); returns what it saw.
  task automatic access3(input bit we, input logic [AW-1:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata, output int lat, output bit stall_ok,
                         output logic [32:0] resp);
    int t0, waited;
    bit seen;
    @(posedge clk); #1;
    bus3.c_req = 1; bus3.c_we = we; bus3.c_addr = addr; bus3.c_size = size; bus3.c_wdata = wdata;
    t0 = cyc; seen = 0; waited = 0; stall_ok = 1; lat = -1; resp = '0;
    while (!seen && waited < 40) begin
      @(negedge clk);
      if (bus3.c_ack) begin
        seen = 1; lat = cyc - t0; resp = {bus3.c_err, bus3.c_rdata};
      end else begin
        waited++;
        if (bus3.c_stall !== 1'b1) stall_ok = 0;
      end
    end
    @(posedge clk); #1;
    bus3.c_req = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (outs1() === '0 && st3 === 2'd0 && busy3 === 1'b0) n_pass++;
    else $display("FAIL reset_outputs: got %h required 0", outs1());
    reset_n = 1;
  endtask

  task automatic test_byte_lanes();
    int m0;
    m0 = men1;
    access1(0, 1, 12'h006, 2'd1, 32'h0000_00AB, 0, 32'd0, 3);
    n_checks++;
    if ({be1, ma1, wd1} === {4'b0100, 10'h001, 32'hABAB_ABAB} && men1 == m0 + 1) n_pass++;
    else $display("FAIL sb_issue: got be=%b addr=%h wd=%h en=%0d required 0100/001/abababab/1",
                  be1, ma1, wd1, men1 - m0);
    access1(0, 0, 12'h006, 2'd1, 32'd0, 0, 32'h0000_00AB, 3);
    n_checks++;
    if (be1 === 4'b0100) n_pass++;
    else $display("FAIL lb_be: got %b required 0100", be1);
  endtask

  task automatic test_half_word();
    access1(0, 1, 12'h008, 2'd3, 32'h1234_ABCD, 0, 32'd0, 3);
    n_checks++;
    if ({be1, wd1} === {4'b1111, 32'h1234_ABCD}) n_pass++;
    else $display("FAIL sw_issue: got be=%b wd=%h required 1111/1234abcd", be1, wd1);
    access1(1, 0, 12'h00A, 2'd2, 32'd0, 0, 32'h0000_1234, 3);
    n_checks++;
    if (be1 === 4'b1100) n_pass++;
    else $display("FAIL lh_be: got %b required 1100", be1);
    access1(0, 0, 12'h008, 2'd2, 32'd0, 0, 32'h0000_ABCD, 3);
    access1(1, 0, 12'h009, 2'd1, 32'd0, 0, 32'h0000_00AB, 3);
    access1(0, 1, 12'h00E, 2'd2, 32'hFFFF_5AA5, 0, 32'd0, 3);
    n_checks++;
    if ({be1, ma1, wd1} === {4'b1100, 10'h003, 32'h5AA5_5AA5}) n_pass++;
    else $display("FAIL sh_issue: got be=%b addr=%h wd=%h required 1100/003/5aa55aa5", be1, ma1, wd1);
    access1(1, 0, 12'h00E, 2'd2, 32'd0, 0, 32'h0000_5AA5, 3);
  endtask

  task automatic test_misaligned();
    int m0;
    m0 = men1;
    access1(0, 0, 12'h002, 2'd3, 32'd0, 1, 32'd0, 1);
    access1(1, 0, 12'h001, 2'd2, 32'd0, 1, 32'd0, 1);
    access1(0, 1, 12'h000, 2'd0, 32'hFFFF_FFFF, 1, 32'd0, 1);
    n_checks++;
    if (men1 == m0) n_pass++;
    else $display("FAIL misaligned_mem_en: got %0d strobes required 0", men1 - m0);
  endtask

  task automatic test_arbitration();
    int waited;
    bit seen;
    logic [33:0] e, g;
    logic [33:0] ec, ex;
    access1(0, 1, 12'h100, 2'd3, 32'h1111_1111, 0, 32'd0, 3);
    access1(1, 1, 12'h200, 2'd3, 32'h2222_2222, 0, 32'd0, 3);
    ec = {1'b0, 1'b0, 32'h1111_1111};
    ex = {1'b1, 1'b0, 32'h2222_2222};
`ifdef DM_ARB_RR_EN
    exp_q.push_back(ec); exp_q.push_back(ex); exp_q.push_back(ec); exp_q.push_back(ex);
`else
    exp_q.push_back(ec); exp_q.push_back(ec); exp_q.push_back(ec); exp_q.push_back(ex);
`endif
    @(posedge clk); #1;
    bus1.c_req = 1; bus1.c_we = 0; bus1.c_addr = 12'h100; bus1.c_size = 2'd3;
    bus1.x_req = 1; bus1.x_we = 0; bus1.x_addr = 12'h200; bus1.x_size = 2'd3;
    for (int i = 0; i < 4; i++) begin
      seen = 0; waited = 0;
      while (!seen && waited < 40) begin
        @(negedge clk);
        if (bus1.c_ack || bus1.x_ack) seen = 1; else waited++;
      end
      e = exp_q.pop_front();
      g = {bus1.x_ack & ~bus1.c_ack, bus1.x_ack ? bus1.x_err : bus1.c_err,
           bus1.x_ack ? bus1.x_rdata : bus1.c_rdata};
      n_checks++;
      if (seen && g === e) n_pass++;
      else $display("FAIL arb_grant_%0d: got %h required %h (seen=%0d)", i, g, e, seen);
      @(posedge clk); #1;
      if (i == 2) bus1.c_req = 0;
`ifdef DM_ARB_RR_EN
      if (i == 2) bus1.c_req = 1;
`endif
    end
    bus1.c_req = 0; bus1.x_req = 0;
  endtask

  task automatic test_latency3();
    int lat;
    bit stall_ok;
    logic [32:0] resp;
    access3(1, 12'h010, 2'd3, 32'hDEAD_BEEF, lat, stall_ok, resp);
    n_checks++;
    if (lat == 5 && stall_ok && resp === 33'd0) n_pass++;
    else $display("FAIL lat3_sw: got lat=%0d stall_ok=%0d resp=%h required 5/1/0", lat, stall_ok, resp);
    n_checks++;
    if ({be3, ma3, wd3} === {4'b1111, 10'h004, 32'hDEAD_BEEF} && men3 == 1) n_pass++;
    else $display("FAIL lat3_issue: got be=%b addr=%h wd=%h en=%0d required 1111/004/deadbeef/1",
                  be3, ma3, wd3, men3);
    access3(0, 12'h010, 2'd3, 32'd0, lat, stall_ok, resp);
    n_checks++;
    if (lat == 5 && resp === {1'b0, 32'hDEAD_BEEF}) n_pass++;
    else $display("FAIL lat3_lw: got lat=%0d resp=%h required 5/0deadbeef", lat, resp);
    access3(0, 12'h013, 2'd1, 32'd0, lat, stall_ok, resp);
    n_checks++;
    if (lat == 5 && resp === {1'b0, 32'h0000_00DE}) n_pass++;
    else $display("FAIL lat3_lb: got lat=%0d resp=%h required 5/0000000de", lat, resp);
  endtask

  task automatic test_reset_mid();
    int a0;
    logic [119:0] o;
    @(posedge clk); #1;
    bus1.c_req = 1; bus1.c_we = 0; bus1.c_addr = 12'h100; bus1.c_size = 2'd3;
    a0 = c_acks1;
    @(posedge clk);
    @(posedge clk); #2;
    n_checks++;
    if (st1 === 2'd2) n_pass++;
    else $display("FAIL mid_state: got %0d required 2 (WAIT)", st1);
    reset_n = 0; #1;
    o = outs1();
    n_checks++;
    if (o === '0) n_pass++;
    else $display("FAIL mid_reset_outputs: got %h required 0", o);
    bus1.c_req = 0;
    @(negedge clk); @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    n_checks++;
    if (busy1 === 1'b0 && st1 === 2'd0 && c_acks1 == a0) n_pass++;
    else $display("FAIL post_reset_idle: got busy=%0d st=%0d acks=%0d required 0/0/0",
                  busy1, st1, c_acks1 - a0);
    access1(0, 0, 12'h008, 2'd3, 32'd0, 0, 32'h1234_ABCD, 3);
    n_checks++;
    if (c_acks1 == a0 + 1) n_pass++;
    else $display("FAIL post_reset_acks: got %0d required 1", c_acks1 - a0);
  endtask

  initial begin
    bus1.c_req = 0; bus1.c_we = 0; bus1.c_addr = '0; bus1.c_size = 0; bus1.c_wdata = 0;
    bus1.x_req = 0; bus1.x_we = 0; bus1.x_addr = '0; bus1.x_size = 0; bus1.x_wdata = 0;
    bus3.c_req = 0; bus3.c_we = 0; bus3.c_addr = '0; bus3.c_size = 0; bus3.c_wdata = 0;
    bus3.x_req = 0; bus3.x_we = 0; bus3.x_addr = '0; bus3.x_size = 0; bus3.x_wdata = 0;
    test_reset();
    test_byte_lanes();
    test_half_word();
    test_misaligned();
    test_arbitration();
    test_latency3();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
